// File: rtl/std_div_pkg.sv
// rtl/std_div_pkg.sv - shared types and helpers for the iterative divider
package std_div_pkg;

  localparam int max_w = 64;
  typedef logic [max_w-1:0] wide_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  function automatic bit bpc_legal(input int width, input int bpc);
    return (bpc == 1 || bpc == 2 || bpc == 4) && (width % bpc == 0) &&
           (width >= 2) && (width <= max_w);
  endfunction

  // Callers truncate the result back to their own width.
  function automatic wide_t abs_mag(input wide_t v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic wide_t apply_sign(input wide_t mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/std_div_iter_if.sv
// rtl/std_div_iter_if.sv - go/done handshake and operand/result bundle
interface std_div_iter_if #(
  parameter int width = 32
);
  logic             go;
  logic [width-1:0] left;
  logic [width-1:0] right;
  logic [width-1:0] out_quotient;
  logic [width-1:0] out_remainder;
  logic             div_by_zero;
  logic             done;

  modport master (
    output go, left, right,
    input  out_quotient, out_remainder, div_by_zero, done
  );

  modport slave (
    input  go, left, right,
    output out_quotient, out_remainder, div_by_zero, done
  );
endinterface

// File: rtl/std_div_step.sv
// rtl/std_div_step.sv - bits_per_cycle restoring shift-subtract steps, MSB first
module std_div_step #(
  parameter int width          = 32,
  parameter int bits_per_cycle = 1
) (
  input  logic [width-1:0]          rem_in,
  input  logic [width-1:0]          dvd_in,
  input  logic [width-1:0]          divisor,
  output logic [width-1:0]          rem_out,
  output logic [width-1:0]          dvd_out,
  output logic [bits_per_cycle-1:0] q_bits
);

  logic [width:0]   trial;
  logic [width-1:0] r;
  logic [width-1:0] d;

  // Partial remainder stays below the divisor, so the trial fits in width+1 bits.
  always_comb begin
    r      = rem_in;
    d      = dvd_in;
    q_bits = '0;
    trial  = '0;
    for (int i = bits_per_cycle - 1; i >= 0; i--) begin
      trial = {r, d[width-1]};
      d     = {d[width-2:0], 1'b0};
      if (trial >= {1'b0, divisor}) begin
        trial     = trial - {1'b0, divisor};
        q_bits[i] = 1'b1;
      end
      r = trial[width-1:0];
    end
    rem_out = r;
    dvd_out = d;
  end

endmodule

// File: rtl/std_div_iter.sv
// rtl/std_div_iter.sv - iterative radix-2^k divider with early-out and defined div-by-zero
module std_div_iter
  import std_div_pkg::*;
#(
  parameter int width          = 32,
  parameter int bits_per_cycle = 1,
  parameter int is_signed      = 0
) (
  input  logic          clk,
  input  logic          reset,
  std_div_iter_if.slave bus
);

  localparam bit signed_mode = (is_signed != 0);
  localparam int steps       = width / bits_per_cycle;
  localparam int cnt_w       = (steps > 1) ? $clog2(steps) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(steps - 1);

  if (!bpc_legal(width, bits_per_cycle)) begin : g_bad_cfg
    $error("std_div_iter: illegal width/bits_per_cycle combination");
  end

  div_state_t                state_q, state_d;
  logic [cnt_w-1:0]          cnt_q;
  logic [width-1:0]          rem_q, dq_q, dvs_q;
  logic                      q_neg_q, r_neg_q;
  logic [width-1:0]          rem_nx, dq_shift, dq_nx;
  logic [bits_per_cycle-1:0] q_bits;
  logic [width-1:0]          out_q_q, out_r_q;
  logic                      dbz_q;
  logic                      zero_div, zero_dvd;

  function automatic logic [width-1:0] mag(input logic [width-1:0] v);
    if (!signed_mode) return v;
    return width'(abs_mag(wide_t'(v), v[width-1]));
  endfunction

  assign zero_div = (bus.right == '0);
  assign zero_dvd = (bus.left == '0);

  // Dividend register doubles as the quotient register: bits shift out the top, results in at the bottom.
  std_div_step #(
    .width          (width),
    .bits_per_cycle (bits_per_cycle)
  ) u_step (
    .rem_in  (rem_q),
    .dvd_in  (dq_q),
    .divisor (dvs_q),
    .rem_out (rem_nx),
    .dvd_out (dq_shift),
    .q_bits  (q_bits)
  );

  assign dq_nx = dq_shift | width'(q_bits);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.go) state_d = (zero_div || zero_dvd) ? FIN : CALC;
      CALC:    if (!bus.go) state_d = IDLE;
               else if (cnt_q == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      out_q_q <= '0;
      out_r_q <= '0;
      dbz_q   <= 1'b0;
    end else if (state_q == IDLE && bus.go) begin
      if (zero_div) begin
        out_q_q <= '1;
        out_r_q <= bus.left;
        dbz_q   <= 1'b1;
      end else if (zero_dvd) begin
        out_q_q <= '0;
        out_r_q <= '0;
        dbz_q   <= 1'b0;
      end else begin
        rem_q   <= '0;
        dq_q    <= mag(bus.left);
        dvs_q   <= mag(bus.right);
        cnt_q   <= cnt_last;
        q_neg_q <= signed_mode && (bus.left[width-1] ^ bus.right[width-1]);
        r_neg_q <= signed_mode && bus.left[width-1];
      end
    end else if (state_q == CALC && bus.go) begin
      rem_q <= rem_nx;
      dq_q  <= dq_nx;
      cnt_q <= cnt_q - cnt_w'(1);
      if (cnt_q == '0) begin
        out_q_q <= width'(apply_sign(wide_t'(dq_nx), q_neg_q));
        out_r_q <= width'(apply_sign(wide_t'(rem_nx), r_neg_q));
        dbz_q   <= 1'b0;
      end
    end
  end

  assign bus.done          = (state_q == FIN);
  assign bus.out_quotient  = out_q_q;
  assign bus.out_remainder = out_r_q;
  assign bus.div_by_zero   = dbz_q;

endmodule

// File: doc/std_div_iter.md
# std_div_iter

Iterative multi-cycle integer divider producing quotient and remainder, with configurable width, bits retired per cycle (radix 2^k), and a signed/unsigned mode. It sits alongside the existing sequential arithmetic primitives and uses the standard go/done handshake. Its new features are an asynchronous reset, a fixed and predictable latency, early-out on zero operands, and defined divide-by-zero and overflow results.

## Interface
Parameters:
- `width`, 32: operand and result width.
- `bits_per_cycle`, 1: quotient bits retired per cycle. Legal values are 1, 2 and 4, and the value must divide `width`. Elaboration error otherwise.
- `is_signed`, 0: 0 selects unsigned mode; 1 selects two's-complement mode.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; all state clears immediately when it is 0.
- `go`  in  1  start request; must stay high until `done`.
- `left`  in  width  dividend; sampled only on the start edge.
- `right`  in  width  divisor; sampled only on the start edge.
- `out_quotient`  out  width  registered quotient.
- `out_remainder`  out  width  registered remainder.
- `div_by_zero`  out  1  registered flag; valid with `done` and held afterwards.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, CALC and FIN. Let N = `width`/`bits_per_cycle`.
- **IDLE, `go`=1, `right`=0** → FIN.
  - Unsigned: quotient is all ones, remainder is `left`, `div_by_zero`=1.
  - Signed: quotient is -1 (all ones), remainder is `left`, `div_by_zero`=1.
- **IDLE, `go`=1, `left`=0, `right`≠0** → FIN. Quotient is 0, remainder is 0, `div_by_zero`=0.
- **IDLE, `go`=1, otherwise** → CALC.
  - Load the operand magnitudes (absolute value in signed mode).
  - Latch the result signs: quotient sign is sign(left) XOR sign(right); remainder sign is sign(left).
  - Clear the partial remainder and load step counter = N-1.
- **CALC**: each edge performs `bits_per_cycle` restoring shift-subtract steps, MSB first.
  - Counter = 0 → FIN.
  - On that same edge, write the sign-corrected results to the output registers and set `div_by_zero`=0.
- **FIN**: `done`=1. The next edge → IDLE unconditionally. If `go` is still high in IDLE, a new operation starts.
- **Abort**: if `go`=0 on any CALC edge, go to IDLE. `done` is not asserted, and the outputs keep their previous values.
- Signed semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative ÷ -1 gives quotient = most-negative (wraps) and remainder 0, with no flag.
  - Internal magnitude datapath is `width` bits unsigned. The magnitude of the most-negative value is representable as unsigned.
- Outputs hold their last result through IDLE until the next FIN entry overwrites them.

## Timing
- Reset: `done`=0, `div_by_zero`=0, `out_quotient`=0, `out_remainder`=0, state IDLE.
  - Takes effect asynchronously, mid-operation included; any in-flight result is discarded.
- Take `go` first high in cycle t, sampled in IDLE.
  - Normal operation: `done` is high in cycle t+N+1.
  - Early-out (zero divisor or zero dividend): `done` is high in cycle t+1.
- `done` is high for exactly one cycle per completed operation.
- Outputs are valid in the `done` cycle and stable until the next completion or reset.
- `left` and `right` may change freely after the start edge.
- Throughput with `go` held high: one result every N+2 cycles (IDLE → CALC×N → FIN).

## Structure
- Shared package `std_div_pkg` holds:
  - the state enum typedef (IDLE, CALC, FIN);
  - the legal `bits_per_cycle` check;
  - an `abs_mag` function (two's-complement magnitude to unsigned);
  - the `apply_sign` function.
- Sub-module `std_div_step`: a combinational block performing `bits_per_cycle` restoring steps.
  - Inputs: partial remainder, dividend bits, divisor.
  - Outputs: new partial remainder, dividend bits, quotient bits.
  - Instantiated once in the top.
- The top holds the FSM, the counter and the output registers.

## Test plan
- Unsigned, `width`=32, `bits_per_cycle`=1, 100/7 → quotient 14, remainder 2, `div_by_zero`=0, `done` at t+33.
- Same 100/7 with `bits_per_cycle`=4 → quotient 14, remainder 2, `done` at t+9.
- Signed, `width`=32:
  - -7/2 → quotient -3, remainder -1.
  - 7/-2 → quotient -3, remainder 1.
  - 0x80000000/-1 → quotient 0x80000000, remainder 0.
- Zero operands:
  - 5/0, unsigned → quotient 0xFFFFFFFF, remainder 5, `div_by_zero`=1, `done` at t+1.
  - 0/9 → quotient 0, remainder 0, `done` at t+1.
- Abort: drop `go` in cycle t+5 of a k=1 operation → no `done` pulse, outputs unchanged from the prior result. A fresh `go` then completes normally.
- Reset mid-CALC: drive `reset`=0 between clock edges → outputs and `done` are 0 immediately. After release, a 42/5 operation yields quotient 8, remainder 2.
